servo_pwm_monitor: RTL and testbench

Measures the servo PWM waveform that `servo` drives onto `pwm_pin`. It is the receive end of the servo pulse interface: it recovers the pulse width in microseconds, in the same units as `servo`'s `pulse_width` input, and it also reports the frame period. It sits beside `SERVO_PAN` and `SERVO_TILT` on `CLOCK_50`, looped back from the GPIO pin. The tracking state machine and the bench use it to confirm commanded angles, out-of-range pulses and dead outputs.

---
 rtl/servo_pwm_monitor.sv | 195 +++++++++++++++++++
 tb/tb_servo_pwm_monitor.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_monitor.sv
// -----------------------------------------------------------------------------
// servo_pwm_monitor
//
// Receive end of the servo pulse interface. Recovers the high time of each
// servo PWM pulse in microseconds (same units as the servo's pulse_width
// command), reports the rise-to-rise frame period, flags out-of-range pulses
// and declares the link dead when the line stops toggling.
//
// Ports:
//   clk           system clock (CLOCK_50)
//   rst_n         synchronous active-low reset
//   pwm_in        asynchronous servo PWM line
//   pulse_width   last measured high time in us, saturates at 2047
//   pulse_valid   one-cycle strobe when pulse_width updates
//   pulse_error   one-cycle strobe with pulse_valid when width is out of range
//   period_us     last rise-to-rise period in us, saturates at 32767
//   period_valid  one-cycle strobe when period_us updates
//   pwm_timeout   level, set once the line has been idle for TIMEOUT_US
// -----------------------------------------------------------------------------
module servo_pwm_monitor #(
    parameter int clock_frequency_mhz = 50,
    parameter int MIN_PULSE_US        = 1000,
    parameter int MAX_PULSE_US        = 2000,
    parameter int TIMEOUT_US          = 40000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pwm_in,
    output logic [10:0] pulse_width,
    output logic        pulse_valid,
    output logic        pulse_error,
    output logic [14:0] period_us,
    output logic        period_valid,
    output logic        pwm_timeout
);

    localparam int PRE_W  = (clock_frequency_mhz > 1) ? $clog2(clock_frequency_mhz) : 1;
    localparam int IDLE_W = $clog2(TIMEOUT_US + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(clock_frequency_mhz - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX  = IDLE_W'(TIMEOUT_US);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_US - 1);
    localparam logic [11:0]       MIN_W     = 12'(MIN_PULSE_US);
    localparam logic [11:0]       MAX_W     = 12'(MAX_PULSE_US);

    typedef enum logic [1:0] {
        WAIT_LOW,
        WAIT_RISE,
        HIGH,
        LOW
    } state_t;

    state_t state_q, state_d;

    // ---------------------------------------------------------------
    // Input conditioning: 2-flop synchronizer plus edge register.
    // ---------------------------------------------------------------
    logic sync_meta, synced, delayed;
    logic rise, fall, any_edge;

    // NOTE: the synchronizer carries no reset so that a line already high
    // when reset releases is seen as high, not as a fresh rising edge.
    // NOTE: sequential state is always assigned with non-blocking <=.
    always_ff @(posedge clk) begin
        sync_meta <= pwm_in;
        synced    <= sync_meta;
        delayed   <= synced;
    end

    assign rise     = synced & ~delayed;
    assign fall     = ~synced & delayed;
    assign any_edge = rise | fall;

    // ---------------------------------------------------------------
    // Microsecond prescaler, restarted on every edge so that both the
    // high and low segments are measured as floor(cycles / freq).
    // ---------------------------------------------------------------
    logic [PRE_W-1:0] presc;
    logic             us_tick;

    assign us_tick = (presc == PRE_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n)                presc <= '0;
        else if (any_edge || us_tick) presc <= '0;
        else                       presc <= presc + PRE_W'(1);
    end

    // ---------------------------------------------------------------
    // Counters. The *_sum values include the tick of the current cycle,
    // which matters on the edge cycle itself where a count is captured.
    // ---------------------------------------------------------------
    logic [10:0]       hi_cnt;
    logic [14:0]       per_cnt;
    logic [IDLE_W-1:0] idle_cnt;
    logic [11:0]       hi_sum;
    logic [15:0]       per_sum;
    logic [10:0]       hi_sat;
    logic [14:0]       per_sat;
    logic              timeout_hit;
    logic              width_bad;

    assign hi_sum      = {1'b0, hi_cnt} + {11'd0, us_tick};
    assign per_sum     = {1'b0, per_cnt} + {15'd0, us_tick};
    assign hi_sat      = hi_sum[11] ? 11'h7FF : hi_sum[10:0];
    assign per_sat     = per_sum[15] ? 15'h7FFF : per_sum[14:0];
    // Range check on the unsaturated sum; any saturated width exceeds MAX.
    assign width_bad   = (hi_sum < MIN_W) || (hi_sum > MAX_W);
    // Fires once, on the tick that brings idle_cnt up to TIMEOUT_US.
    assign timeout_hit = us_tick && (idle_cnt == IDLE_LAST);

    // ---------------------------------------------------------------
    // Tracking FSM
    // ---------------------------------------------------------------
    logic load_pw, load_per, clr_cnt, set_to;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= WAIT_LOW;
        else        state_q <= state_d;
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        load_pw  = 1'b0;
        load_per = 1'b0;
        clr_cnt  = 1'b0;
        set_to   = 1'b0;
        if (timeout_hit) begin
            // Timeout outranks an edge in the same cycle; that edge is dropped.
            state_d = WAIT_LOW;
            set_to  = 1'b1;
        end else begin
            case (state_q)
                WAIT_LOW:  if (!synced) state_d = WAIT_RISE;
                WAIT_RISE: if (rise) begin
                    state_d = HIGH;
                    clr_cnt = 1'b1;
                end
                HIGH:      if (fall) begin
                    state_d = LOW;
                    load_pw = 1'b1;
                end
                LOW:       if (rise) begin
                    state_d  = HIGH;
                    load_per = 1'b1;
                    clr_cnt  = 1'b1;
                end
                default:   state_d = WAIT_LOW;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi_cnt   <= '0;
            per_cnt  <= '0;
            idle_cnt <= '0;
        end else begin
            if (clr_cnt) begin
                hi_cnt  <= '0;
                per_cnt <= '0;
            end else begin
                if (state_q == HIGH)                     hi_cnt  <= hi_sat;
                if (state_q == HIGH || state_q == LOW)   per_cnt <= per_sat;
            end
            if (any_edge)                              idle_cnt <= '0;
            else if (us_tick && idle_cnt != IDLE_MAX)  idle_cnt <= idle_cnt + IDLE_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pulse_width  <= '0;
            pulse_valid  <= 1'b0;
            pulse_error  <= 1'b0;
            period_us    <= '0;
            period_valid <= 1'b0;
            pwm_timeout  <= 1'b0;
        end else begin
            pulse_valid  <= load_pw;
            pulse_error  <= load_pw && width_bad;
            period_valid <= load_per;
            if (load_pw)  pulse_width <= hi_sat;
            if (load_per) period_us   <= per_sat;
            if (set_to)       pwm_timeout <= 1'b1;
            else if (load_pw) pwm_timeout <= 1'b0;
        end
    end

endmodule

// File: tb/tb_servo_pwm_monitor.sv
// -----------------------------------------------------------------------------
// tb_servo_pwm_monitor
//
// Directed bench for servo_pwm_monitor. Runs the monitor with a 2-cycle
// microsecond and a 3500 us timeout so every scenario fits a short run;
// pulse lengths are given in clk cycles and expected values in us.
// -----------------------------------------------------------------------------
module tb_servo_pwm_monitor;

    localparam int F = 2;
    localparam int T = 3500;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pwm_in = 1'b0;
    logic [10:0] pulse_width;
    logic        pulse_valid;
    logic        pulse_error;
    logic [14:0] period_us;
    logic        period_valid;
    logic        pwm_timeout;

    servo_pwm_monitor #(
        .clock_frequency_mhz(F),
        .MIN_PULSE_US(1000),
        .MAX_PULSE_US(2000),
        .TIMEOUT_US(T)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .pwm_in(pwm_in),
        .pulse_width(pulse_width),
        .pulse_valid(pulse_valid),
        .pulse_error(pulse_error),
        .period_us(period_us),
        .period_valid(period_valid),
        .pwm_timeout(pwm_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Strobe capture, sampled on the falling edge.
    int pv_cnt = 0, pw_cap = 0, pe_cap = 0, pv_cyc = 0;
    int per_cnt_tb = 0, per_cap = 0, per_cyc = 0;
    int to_cyc = 0;
    logic to_prev = 1'b0;

    always @(negedge clk) begin
        if (pulse_valid) begin
            pv_cnt = pv_cnt + 1;
            pw_cap = int'(pulse_width);
            pe_cap = int'(pulse_error);
            pv_cyc = cyc;
        end
        if (period_valid) begin
            per_cnt_tb = per_cnt_tb + 1;
            per_cap    = int'(period_us);
            per_cyc    = cyc;
        end
        if (pwm_timeout && !to_prev) to_cyc = cyc;
        to_prev = pwm_timeout;
    end

    int checks = 0, errors = 0;
    int rise_chg = 0, fall_chg = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance n clocks, leaving the bench 1 time unit after a rising edge.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Pin high for h cycles then low for l cycles; records the edge at which
    // each pin change is first sampled.
    task automatic pulse(input int h, input int l);
        pwm_in   = 1'b1;
        rise_chg = cyc + 1;
        step(h);
        pwm_in   = 1'b0;
        fall_chg = cyc + 1;
        step(l);
    endtask

    task automatic check_pulse(input string tag, input int pv0, input int w, input int e);
        check({tag, "_count"}, pv_cnt, pv0 + 1);
        check({tag, "_width"}, pw_cap, w);
        check({tag, "_error"}, pe_cap, e);
    endtask

    int bh[5] = '{2999, 2000, 1998, 4002, 6000};
    int bw[5] = '{1499, 1000,  999, 2001, 2047};
    int be[5] = '{   0,    0,    1,    1,    1};

    initial begin
        int pv0, pc0, tie_chg;

        // Reset state
        step(5);
        check("reset_outputs",
              {pulse_width, period_us, pulse_valid, pulse_error, period_valid, pwm_timeout}, 0);
        rst_n = 1'b1;
        step(5);

        // Nominal: 1500 us high / 500 us low, three frames
        for (int i = 0; i < 3; i++) begin
            pv0 = pv_cnt;
            pc0 = per_cnt_tb;
            pulse(3000, 1000);
            check_pulse("nominal", pv0, 1500, 0);
            check("nominal_pv_latency", pv_cyc - fall_chg, 2);
            check("nominal_period_count", per_cnt_tb, pc0 + ((i > 0) ? 1 : 0));
            if (i > 0) begin
                check("nominal_period", per_cap, 2000);
                check("nominal_period_latency", per_cyc - rise_chg, 2);
            end
        end

        // Truncation and range bounds, 300 us low between pulses
        for (int i = 0; i < 5; i++) begin
            pv0 = pv_cnt;
            pulse(bh[i], 600);
            check_pulse("bounds", pv0, bw[i], be[i]);
            if (i == 1) check("bounds_period", per_cap, 1799);
        end

        // Timeout: line held low after the 3000 us pulse
        step(6500);
        check("timeout_level", pwm_timeout, 1);
        check("timeout_time", to_cyc - fall_chg, 2 + 2 * T);
        pv0 = pv_cnt;
        pc0 = per_cnt_tb;
        pulse(2400, 600);
        check_pulse("after_timeout", pv0, 1200, 0);
        check("timeout_cleared", pwm_timeout, 0);
        check("timeout_no_period", per_cnt_tb, pc0);
        pulse(2400, 600);
        check("timeout_second_rise_count", per_cnt_tb, pc0 + 1);
        check("timeout_second_rise_period", per_cap, 1500);

        // Edge vs timeout tie: rise lands on the timeout tick
        pv0 = pv_cnt;
        pulse(3000, 2 * T);
        check_pulse("tie_pre", pv0, 1500, 0);
        pwm_in  = 1'b1;
        tie_chg = cyc + 1;
        pv0     = pv_cnt;
        step(3000);
        pwm_in = 1'b0;
        step(600);
        check("tie_timeout_time", to_cyc - tie_chg, 2);
        check("tie_timeout_level", pwm_timeout, 1);
        check("tie_no_pulse", pv_cnt, pv0);
        pulse(3000, 600);
        check_pulse("tie_post", pv0, 1500, 0);
        check("tie_timeout_cleared", pwm_timeout, 0);

        // Reset 700 us into a 1500 us pulse
        pwm_in = 1'b1;
        step(1400);
        rst_n = 1'b0;
        step(1);
        check("midreset_outputs",
              {pulse_width, period_us, pulse_valid, pulse_error, period_valid, pwm_timeout}, 0);
        rst_n = 1'b1;
        pv0 = pv_cnt;
        pc0 = per_cnt_tb;
        step(1600);
        pwm_in = 1'b0;
        step(600);
        check("midreset_no_pulse", pv_cnt, pv0);
        pulse(3000, 600);
        check_pulse("midreset_post", pv0, 1500, 0);
        check("midreset_no_period", per_cnt_tb, pc0);

        // Line already high when reset releases
        pwm_in = 1'b1;
        step(10);
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        pv0 = pv_cnt;
        pc0 = per_cnt_tb;
        step(2000);
        pwm_in = 1'b0;
        step(600);
        check("starthigh_no_pulse", pv_cnt, pv0);
        pulse(3000, 600);
        check_pulse("starthigh_post", pv0, 1500, 0);
        check("starthigh_no_period", per_cnt_tb, pc0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
